// File: rtl/dummy_stream_pkg.sv
// Shared definitions for the dummy AXI-Stream source/sink pair:
// FSM state encoding and the packet counter width.
package dummy_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } stream_state_e;

    localparam int PKT_CNT_W = 32;

endpackage

// File: rtl/dummy_source_master_stream.sv
// AXI-Stream master that emits packets of an incrementing word counter,
// separated by a fixed idle gap, optionally stopping after N packets.
module dummy_source_master_stream
    import dummy_stream_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 64,
    parameter int C_PKT_LEN            = 16,
    parameter int C_GAP_CYCLES         = 4,
    parameter int C_NUM_PKTS           = 0
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              EN,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic                              DONE,
    output logic [PKT_CNT_W-1:0]              PKT_CNT
);

    localparam int BEAT_W = (C_PKT_LEN > 1) ? $clog2(C_PKT_LEN) : 1;
    localparam int GAP_W  = (C_GAP_CYCLES > 1) ? $clog2(C_GAP_CYCLES) : 1;

    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(C_PKT_LEN - 1);
    localparam logic [GAP_W-1:0]     LAST_GAP  = GAP_W'(C_GAP_CYCLES - 1);
    localparam logic [PKT_CNT_W-1:0] NUM_PKTS  = PKT_CNT_W'(C_NUM_PKTS);

    stream_state_e                   state;
    stream_state_e                   state_nxt;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] word_cnt;
    logic [BEAT_W-1:0]               beat_idx;
    logic [GAP_W-1:0]                gap_cnt;
    logic [PKT_CNT_W-1:0]            pkt_cnt;
    logic [PKT_CNT_W-1:0]            pkt_cnt_inc;
    logic                            xfer;
    logic                            last_xfer;

    // All outputs decode directly from registered state, so they stay stable during a stall.
    assign M_AXIS_TVALID = (state == SEND);
    assign M_AXIS_TLAST  = (state == SEND) && (beat_idx == LAST_BEAT);
    assign M_AXIS_TDATA  = word_cnt;
    assign M_AXIS_TSTRB  = '1;
    assign DONE          = (state == FINISH);
    assign PKT_CNT       = pkt_cnt;

    assign xfer        = (state == SEND) && M_AXIS_TREADY;
    assign last_xfer   = xfer && (beat_idx == LAST_BEAT);
    assign pkt_cnt_inc = pkt_cnt + 32'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (EN) state_nxt = SEND;
            end
            SEND: begin
                // EN is only consulted at a packet boundary, never mid-packet.
                if (last_xfer) begin
                    if ((C_NUM_PKTS != 0) && (pkt_cnt_inc == NUM_PKTS)) state_nxt = FINISH;
                    else if (!EN)                                        state_nxt = IDLE;
                    else if (C_GAP_CYCLES == 0)                          state_nxt = SEND;
                    else                                                 state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) state_nxt = SEND;
            end
            FINISH: begin
                state_nxt = FINISH;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state    <= IDLE;
            word_cnt <= '0;
            beat_idx <= '0;
            gap_cnt  <= '0;
            pkt_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                word_cnt <= word_cnt + 1'b1;
                beat_idx <= last_xfer ? '0 : beat_idx + 1'b1;
            end
            if (last_xfer) pkt_cnt <= pkt_cnt_inc;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_dummy_source_master_stream.sv
// Directed bench for dummy_source_master_stream: three instances cover the
// default, finite-packet and back-to-back single-beat configurations.
module tb_dummy_source_master_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: defaults (64-bit, 16 beats, 4 gap cycles, unlimited)
    logic        a_rstn, a_en, a_tready, a_tvalid, a_tlast, a_done;
    logic [63:0] a_tdata;
    logic [7:0]  a_tstrb;
    logic [31:0] a_pkt_cnt;

    // Instance B: 32-bit, 4 beats, 3 packets then stop
    logic        b_rstn, b_en, b_tready, b_tvalid, b_tlast, b_done;
    logic [31:0] b_tdata;
    logic [3:0]  b_tstrb;
    logic [31:0] b_pkt_cnt;

    // Instance C: 64-bit, 1 beat, no gap
    logic        c_rstn, c_en, c_tready, c_tvalid, c_tlast, c_done;
    logic [63:0] c_tdata;
    logic [7:0]  c_tstrb;
    logic [31:0] c_pkt_cnt;

    dummy_source_master_stream u_a (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(a_rstn), .EN(a_en),
        .M_AXIS_TVALID(a_tvalid), .M_AXIS_TDATA(a_tdata), .M_AXIS_TSTRB(a_tstrb),
        .M_AXIS_TLAST(a_tlast), .M_AXIS_TREADY(a_tready), .DONE(a_done), .PKT_CNT(a_pkt_cnt)
    );

    dummy_source_master_stream #(
        .C_M_AXIS_TDATA_WIDTH(32), .C_PKT_LEN(4), .C_GAP_CYCLES(4), .C_NUM_PKTS(3)
    ) u_b (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(b_rstn), .EN(b_en),
        .M_AXIS_TVALID(b_tvalid), .M_AXIS_TDATA(b_tdata), .M_AXIS_TSTRB(b_tstrb),
        .M_AXIS_TLAST(b_tlast), .M_AXIS_TREADY(b_tready), .DONE(b_done), .PKT_CNT(b_pkt_cnt)
    );

    dummy_source_master_stream #(
        .C_M_AXIS_TDATA_WIDTH(64), .C_PKT_LEN(1), .C_GAP_CYCLES(0), .C_NUM_PKTS(0)
    ) u_c (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(c_rstn), .EN(c_en),
        .M_AXIS_TVALID(c_tvalid), .M_AXIS_TDATA(c_tdata), .M_AXIS_TSTRB(c_tstrb),
        .M_AXIS_TLAST(c_tlast), .M_AXIS_TREADY(c_tready), .DONE(c_done), .PKT_CNT(c_pkt_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rstn = 1'b0;
        a_en   = 1'b0;
        tick();
        tick();
        a_rstn = 1'b1;
    endtask

    task automatic test_reset();
        a_rstn = 1'b0; b_rstn = 1'b0; c_rstn = 1'b0;
        a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
        a_tready = 1'b1; b_tready = 1'b1; c_tready = 1'b1;
        repeat (3) tick();
        n_checks++; if (a_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_a_tvalid: got %b want 0", a_tvalid); end
        n_checks++; if (a_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_a_tlast: got %b want 0", a_tlast); end
        n_checks++; if (a_tdata !== 64'd0) begin n_fail++; $display("FAIL reset_a_tdata: got %0d want 0", a_tdata); end
        n_checks++; if (a_pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_a_pkt_cnt: got %0d want 0", a_pkt_cnt); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_a_done: got %b want 0", a_done); end
        n_checks++; if (a_tstrb !== 8'hFF) begin n_fail++; $display("FAIL reset_a_tstrb: got %h want ff", a_tstrb); end
        n_checks++; if (b_tvalid !== 1'b0 || b_done !== 1'b0) begin n_fail++; $display("FAIL reset_b: tvalid %b done %b want 0 0", b_tvalid, b_done); end
        n_checks++; if (b_tstrb !== 4'hF) begin n_fail++; $display("FAIL reset_b_tstrb: got %h want f", b_tstrb); end
        n_checks++; if (c_tvalid !== 1'b0 || c_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_c: tvalid %b tlast %b want 0 0", c_tvalid, c_tlast); end
        n_checks++; if (c_pkt_cnt !== 32'd0 || c_done !== 1'b0) begin n_fail++; $display("FAIL reset_c_cnt: pkt_cnt %0d done %b want 0 0", c_pkt_cnt, c_done); end
        a_rstn = 1'b1; b_rstn = 1'b1; c_rstn = 1'b1;
        tick();
        n_checks++; if (a_tvalid !== 1'b0) begin n_fail++; $display("FAIL idle_no_en_tvalid: got %b want 0", a_tvalid); end
    endtask

    // EN is pulsed for one cycle to start; it is raised again mid-packet (not
    // sampled there) so that the packet boundary sees EN=1 and takes the gap.
    task automatic test_basic();
        reset_a();
        a_tready = 1'b1;
        a_en = 1'b1;
        tick();
        a_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 10) a_en = 1'b1;
            n_checks++; if (a_tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_p0_tvalid[%0d]: got %b want 1", i, a_tvalid); end
            n_checks++; if (a_tdata !== 64'(i)) begin n_fail++; $display("FAIL basic_p0_tdata[%0d]: got %0d want %0d", i, a_tdata, i); end
            n_checks++; if (a_tlast !== (i == 15)) begin n_fail++; $display("FAIL basic_p0_tlast[%0d]: got %b want %b", i, a_tlast, (i == 15)); end
            tick();
        end
        n_checks++; if (a_pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL basic_pkt_cnt1: got %0d want 1", a_pkt_cnt); end
        for (int g = 0; g < 4; g++) begin
            n_checks++; if (a_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_gap_tvalid[%0d]: got %b want 0", g, a_tvalid); end
            tick();
        end
        for (int i = 16; i < 32; i++) begin
            n_checks++; if (a_tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_p1_tvalid[%0d]: got %b want 1", i, a_tvalid); end
            n_checks++; if (a_tdata !== 64'(i)) begin n_fail++; $display("FAIL basic_p1_tdata[%0d]: got %0d want %0d", i, a_tdata, i); end
            n_checks++; if (a_tlast !== (i == 31)) begin n_fail++; $display("FAIL basic_p1_tlast[%0d]: got %b want %b", i, a_tlast, (i == 31)); end
            tick();
        end
        n_checks++; if (a_pkt_cnt !== 32'd2) begin n_fail++; $display("FAIL basic_pkt_cnt2: got %0d want 2", a_pkt_cnt); end
    endtask

    task automatic test_en_drop();
        reset_a();
        a_tready = 1'b1;
        a_en = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) a_en = 1'b0;
            n_checks++; if (a_tvalid !== 1'b1) begin n_fail++; $display("FAIL endrop_tvalid[%0d]: got %b want 1", i, a_tvalid); end
            n_checks++; if (a_tdata !== 64'(i)) begin n_fail++; $display("FAIL endrop_tdata[%0d]: got %0d want %0d", i, a_tdata, i); end
            n_checks++; if (a_tlast !== (i == 15)) begin n_fail++; $display("FAIL endrop_tlast[%0d]: got %b want %b", i, a_tlast, (i == 15)); end
            tick();
        end
        n_checks++; if (a_pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL endrop_pkt_cnt: got %0d want 1", a_pkt_cnt); end
        // Longer than the gap, so a stray GAP->SEND would show up here.
        for (int k = 0; k < 7; k++) begin
            n_checks++; if (a_tvalid !== 1'b0) begin n_fail++; $display("FAIL endrop_idle_tvalid[%0d]: got %b want 0", k, a_tvalid); end
            tick();
        end
        a_en = 1'b1;
        tick();
        n_checks++; if (a_tvalid !== 1'b1) begin n_fail++; $display("FAIL endrop_resume_tvalid: got %b want 1", a_tvalid); end
        n_checks++; if (a_tdata !== 64'd16) begin n_fail++; $display("FAIL endrop_resume_tdata: got %0d want 16", a_tdata); end
    endtask

    task automatic test_stall();
        int    exp_word;
        logic  prev_stall, prev_last, do_xfer;
        logic [63:0] prev_data;
        reset_a();
        a_en = 1'b1;
        exp_word = 0;
        prev_stall = 1'b0;
        prev_last = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (prev_stall) begin
                n_checks++; if (a_tvalid !== 1'b1) begin n_fail++; $display("FAIL stall_tvalid_drop[%0d]: got %b want 1", cyc, a_tvalid); end
                n_checks++; if (a_tdata !== prev_data || a_tlast !== prev_last) begin n_fail++; $display("FAIL stall_hold[%0d]: got %0d/%b want %0d/%b", cyc, a_tdata, a_tlast, prev_data, prev_last); end
            end
            if (a_tvalid) begin
                n_checks++; if (a_tdata !== 64'(exp_word)) begin n_fail++; $display("FAIL stall_seq[%0d]: got %0d want %0d", cyc, a_tdata, exp_word); end
                n_checks++; if (a_tlast !== (exp_word % 16 == 15)) begin n_fail++; $display("FAIL stall_tlast[%0d]: got %b want %b", cyc, a_tlast, (exp_word % 16 == 15)); end
            end
            a_tready   = 1'($urandom_range(0, 1));
            prev_stall = a_tvalid && !a_tready;
            prev_data  = a_tdata;
            prev_last  = a_tlast;
            do_xfer    = a_tvalid && a_tready;
            tick();
            if (do_xfer) exp_word++;
        end
        n_checks++; if (exp_word < 50) begin n_fail++; $display("FAIL stall_progress: got %0d transfers want >= 50", exp_word); end
        n_checks++; if (a_pkt_cnt !== 32'(exp_word / 16)) begin n_fail++; $display("FAIL stall_pkt_cnt: got %0d want %0d", a_pkt_cnt, exp_word / 16); end
        a_tready = 1'b1;
    endtask

    // Reset lands on beat 7 of the second packet (word 23), after one packet has completed.
    task automatic test_reset_mid();
        bit found;
        reset_a();
        a_tready = 1'b1;
        a_en = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 60 && !found; cyc++) begin
            tick();
            if (a_tvalid && a_tdata == 64'd23) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_reach_beat: got timeout want word 23 presented"); end
        n_checks++; if (a_pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL rstmid_pkt_cnt_before: got %0d want 1", a_pkt_cnt); end
        a_rstn = 1'b0;
        tick();
        n_checks++; if (a_tvalid !== 1'b0 || a_tlast !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: tvalid %b tlast %b want 0 0", a_tvalid, a_tlast); end
        n_checks++; if (a_pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL rstmid_pkt_cnt: got %0d want 0", a_pkt_cnt); end
        n_checks++; if (a_tdata !== 64'd0) begin n_fail++; $display("FAIL rstmid_tdata: got %0d want 0", a_tdata); end
        a_rstn = 1'b1;
        tick();
        n_checks++; if (a_tvalid !== 1'b1 || a_tdata !== 64'd0) begin n_fail++; $display("FAIL rstmid_restart: tvalid %b tdata %0d want 1 0", a_tvalid, a_tdata); end
        tick();
        n_checks++; if (a_tdata !== 64'd1 || a_tlast !== 1'b0) begin n_fail++; $display("FAIL rstmid_restart_beat1: tdata %0d tlast %b want 1 0", a_tdata, a_tlast); end
    endtask

    task automatic test_num_pkts();
        int cnt;
        b_rstn = 1'b0;
        tick();
        b_rstn = 1'b1;
        b_en = 1'b1;
        b_tready = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 100 && cnt < 12; cyc++) begin
            if (b_tvalid) begin
                n_checks++; if (b_tdata !== 32'(cnt)) begin n_fail++; $display("FAIL npkts_tdata[%0d]: got %0d want %0d", cnt, b_tdata, cnt); end
                n_checks++; if (b_tlast !== (cnt % 4 == 3)) begin n_fail++; $display("FAIL npkts_tlast[%0d]: got %b want %b", cnt, b_tlast, (cnt % 4 == 3)); end
                n_checks++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL npkts_early_done[%0d]: got %b want 0", cnt, b_done); end
                cnt++;
            end
            tick();
        end
        n_checks++; if (cnt != 12) begin n_fail++; $display("FAIL npkts_beats: got %0d want 12", cnt); end
        n_checks++; if (b_done !== 1'b1) begin n_fail++; $display("FAIL npkts_done: got %b want 1", b_done); end
        n_checks++; if (b_pkt_cnt !== 32'd3) begin n_fail++; $display("FAIL npkts_pkt_cnt: got %0d want 3", b_pkt_cnt); end
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (b_tvalid !== 1'b0 || b_done !== 1'b1) begin n_fail++; $display("FAIL npkts_finish[%0d]: tvalid %b done %b want 0 1", k, b_tvalid, b_done); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        c_rstn = 1'b0;
        tick();
        c_rstn = 1'b1;
        c_en = 1'b1;
        c_tready = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (c_tvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_tvalid[%0d]: got %b want 1", i, c_tvalid); end
            n_checks++; if (c_tlast !== 1'b1) begin n_fail++; $display("FAIL b2b_tlast[%0d]: got %b want 1", i, c_tlast); end
            n_checks++; if (c_tdata !== 64'(i)) begin n_fail++; $display("FAIL b2b_tdata[%0d]: got %0d want %0d", i, c_tdata, i); end
            n_checks++; if (c_pkt_cnt !== 32'(i)) begin n_fail++; $display("FAIL b2b_pkt_cnt[%0d]: got %0d want %0d", i, c_pkt_cnt, i); end
            tick();
        end
    endtask

    initial begin
        a_rstn = 1'b0; b_rstn = 1'b0; c_rstn = 1'b0;
        a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
        a_tready = 1'b1; b_tready = 1'b1; c_tready = 1'b1;
        test_reset();
        test_basic();
        test_en_drop();
        test_stall();
        test_reset_mid();
        test_num_pkts();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dummy_source_master_stream.md
DUMMY_SOURCE_MASTER_STREAM -- requirements
Module: dummy_source_master_stream

Interface
REQ-001 SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 64: TDATA width in bits, a multiple of 8 and at least 32.
REQ-002 SHALL have parameter C_PKT_LEN, default 16: beats per packet, at least 1.
REQ-003 SHALL have parameter C_GAP_CYCLES, default 4: idle cycles between packets, 0 allowed.
REQ-004 SHALL have parameter C_NUM_PKTS, default 0: packets to send before stopping; 0 means unlimited.
REQ-005 SHALL have port M_AXIS_ACLK, input, 1 bit: the only clock.
REQ-006 SHALL have port M_AXIS_ARESETN, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port EN, input, 1 bit: generation enable.
REQ-008 SHALL have port M_AXIS_TVALID, output, 1 bit: data valid.
REQ-009 SHALL have port M_AXIS_TDATA, output, C_M_AXIS_TDATA_WIDTH bits: payload.
REQ-010 SHALL have port M_AXIS_TSTRB, output, C_M_AXIS_TDATA_WIDTH/8 bits: byte qualifier.
REQ-011 SHALL have port M_AXIS_TLAST, output, 1 bit: last beat of packet.
REQ-012 SHALL have port M_AXIS_TREADY, input, 1 bit: downstream ready.
REQ-013 SHALL have port DONE, output, 1 bit: C_NUM_PKTS packets sent.
REQ-014 SHALL have port PKT_CNT, output, 32 bits: count of completed packets.

Function
REQ-015 SHALL implement an FSM with states IDLE, SEND, GAP and FINISH; reset state is IDLE.
REQ-016 SHALL go IDLE -> SEND on the clock edge where EN=1, with TVALID=1 from the next cycle.
REQ-017 SHALL treat a beat as transferred only on a cycle with TVALID=1 and TREADY=1.
REQ-018 SHALL hold TVALID, TDATA and TLAST stable while TVALID=1 and TREADY=0; TVALID is never withdrawn without a transfer.
REQ-019 SHALL drive TDATA from a word counter that starts at 0 after reset, increments by 1 per transfer, is zero-extended to the TDATA width, and wraps modulo 2^width.
REQ-020 SHALL drive TSTRB all-ones at all times.
REQ-021 SHALL assert TLAST only on beat index C_PKT_LEN-1 of each packet; when C_PKT_LEN=1, every beat carries TLAST.
REQ-022 SHALL increment PKT_CNT by 1 on each TLAST transfer; PKT_CNT wraps at 2^32.
REQ-023 SHALL, after a TLAST transfer, apply the first matching rule:
- C_NUM_PKTS != 0 and the new PKT_CNT = C_NUM_PKTS -> FINISH.
- EN=0 -> IDLE.
- C_GAP_CYCLES=0 -> stay in SEND, TVALID held high (back-to-back packets).
- Otherwise -> GAP.
REQ-024 SHALL, in GAP, hold TVALID=0 for exactly C_GAP_CYCLES cycles, then return to SEND; EN is not sampled in GAP.
REQ-025 SHALL sample EN only in IDLE and at packet boundaries; EN=0 mid-packet never truncates a packet.
REQ-026 SHALL, in FINISH, hold DONE=1 and TVALID=0 until reset and ignore EN.
REQ-027 SHALL NOT reset the word counter between packets; it is cleared only by reset.

Reset
REQ-028 SHALL, on an edge with M_AXIS_ARESETN=0, set: state=IDLE, TVALID=0, TLAST=0, TDATA=0, word counter=0, beat index=0, PKT_CNT=0, DONE=0.
REQ-029 SHALL, on reset mid-packet, drop TVALID at the next edge with no TLAST emitted; the partial packet is abandoned.
REQ-030 SHALL hold TVALID=0 for at least one cycle after reset deasserts.

Structure
REQ-031 SHALL place the FSM state encoding and the PKT_CNT width constant (32) in shared package dummy_stream_pkg, reused by the paired sink.
REQ-032 SHALL be a single module with no sub-modules; the beat and gap counters are sized with $clog2 of the parameters.

Verification
REQ-033 SHALL verify defaults, TREADY=1, EN pulsed 1 cycle: packet 0 carries TDATA 0..15 with TLAST on 15; 4 idle cycles follow; packet 1 carries 16..31.
REQ-034 SHALL verify random TREADY (50%): TDATA/TLAST stable during every stall, no TVALID drop without transfer, and the sequence is gapless 0,1,2,...
REQ-035 SHALL verify C_NUM_PKTS=3, C_PKT_LEN=4: after beat 11 transfers, DONE=1, PKT_CNT=3, TVALID stays 0 even with EN=1.
REQ-036 SHALL verify C_GAP_CYCLES=0, C_PKT_LEN=1: TVALID stays continuously high and TLAST=1 on every beat.
REQ-037 SHALL verify EN dropped at beat 5 of 16: the packet completes to TLAST, then IDLE; EN reasserted resumes with TDATA=16.
REQ-038 SHALL verify reset asserted at beat 7: next cycle TVALID=0 and PKT_CNT=0; restart begins with TDATA=0.
